clk_div_prog: RTL and testbench
===============================

// Module: clk_div_prog
// PURPOSE
//  Multi-channel programmable clock/tick divider; successor of the fixed single-output divider.
//  Each channel divides clk by a run-time divisor and gives a ~50% duty enable-clock plus a one-cycle tick.
//  Divisor changes are applied only at a period boundary, so clk_out never glitches or runts.
//  Feeds LED blink/scan logic; consumers use tick as a clock enable and clk_out for visible/debug outputs.
// PARAMETERS
//  N_CH     4            number of independent channels (1..16)
//  CH_W     2            width of cfg_ch, >= clog2(N_CH)
//  DIV_W    27           divisor width in bits
//  DEF_DIV  100_000_000  divisor loaded into every channel at reset (1 Hz at 100 MHz)
// PORTS
//  clk       in   1            system clock
//  resetn    in   1            asynchronous active-low reset
//  en        in   N_CH         per-channel run enable
//  cfg_wr    in   1            one-cycle write strobe for a new divisor
//  cfg_ch    in   CH_W         target channel of cfg_wr
//  cfg_div   in   DIV_W        new divisor D
//  cfg_pend  out  N_CH         1 = written divisor waiting for a boundary
//  clk_out   out  N_CH         divided clock, registered
//  tick      out  N_CH         one-cycle pulse, once per period, registered
// BEHAVIOUR
//  Reset (async, resetn=0): cnt=0, D=DEF_DIV, pending=0, cfg_pend=0, clk_out=0, tick=0.
//  Per-channel state: cnt[DIV_W], D[DIV_W], pend_div[DIV_W], pend flag.
//  H = (D+1)>>1 (high length; odd D is high one cycle longer than low).
//  Run (en=1, D>=1), each clk edge:
//   - cnt_nxt = (cnt==D-1) ? 0 : cnt+1; wrap = (cnt==D-1).
//   - tick <= wrap, so tick is high for the one cycle where cnt==0 after a wrap.
//   - clk_out <= (cnt_nxt < H).
//   - Period is exactly D clk cycles. D=1: tick and clk_out stay 1.
//  Hold (en=0): cnt and clk_out hold; tick <= 0.
//  Stall (D=0): cnt <= 0, clk_out <= 0, tick <= 0.
//  Config write (cfg_wr=1, cfg_ch<N_CH): pend_div[cfg_ch] <= cfg_div, pend <= 1.
//   - A second write before apply overwrites pend_div (last write wins).
//   - cfg_ch>=N_CH: write ignored, no state change.
//  Apply of a pending divisor happens on the first edge where any of these holds:
//   - wrap (running), or
//   - en=0 (held), or
//   - D=0 (stalled).
//  Effect of apply:
//   - D <= pend_div, cnt <= 0, pend <= 0.
//   - At wrap: tick <= 1 and clk_out <= (pend_div>=1).
//   - While held or stalled: tick <= 0 and clk_out <= 0.
//  Write and apply on the same edge to the same channel:
//   - The apply uses the old pend_div.
//   - The new value becomes pending (pend stays 1) and is applied at the next boundary.
//  Write landing on an edge where no value is pending and a wrap occurs: no apply on that edge;
//   the value becomes pending for the next boundary.
//  cfg_pend = pend flags, registered; it rises the edge after the write.
//  Channels are fully independent; no cross-channel phase alignment.
//  resetn asserted mid-period: immediate return to reset values, no completion of the period.
// TESTING
//  1 DEF_DIV=4, en=1 after reset -> every channel: clk_out 1,1,0,0 repeating; tick one cycle every 4.
//  2 Write D=5 to ch1 while en[1]=0 -> applied next edge; after en=1: clk_out 3 high/2 low, tick period 5.
//  3 ch0 running D=4, write D=2 at cnt=1 -> cfg_pend[0]=1; old period completes (4 cycles total);
//    then period 2; cfg_pend clears at the wrap; no pulse shorter than 1 cycle.
//  4 Write D=0 to ch2, then D=3 -> stall with clk_out=0 and tick=0; the D=3 write applies next edge;
//    ch2 then runs clk_out 2 high/1 low.
//  5 Two writes to ch3 before its wrap (6, then 8); cfg_ch=5 write with N_CH=4 -> ch3 gets 8;
//    no channel changes from the out-of-range write.
//  6 Drop resetn for 1 cycle mid-period -> all outputs 0 immediately; D=DEF_DIV;
//    the first tick comes DEF_DIV cycles after release.

Source files
------------

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock/tick divider with glitch-free divisor updates.
// Each channel yields a ~50% duty divided clock and a one-cycle tick per period.
module clk_div_prog #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned CH_W    = 2,
  parameter int unsigned DIV_W   = 27,
  parameter int unsigned DEF_DIV = 100_000_000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [N_CH-1:0]   en,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic [N_CH-1:0]   cfg_pend,
  output logic [N_CH-1:0]   clk_out,
  output logic [N_CH-1:0]   tick
);

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] pdiv_q;
    logic             pend_q;
    logic             clk_q;
    logic             tick_q;

    logic [DIV_W-1:0] cnt_nxt;
    logic [DIV_W-1:0] half;
    logic             wr_hit;
    logic             stall;
    logic             run;
    logic             wrap;
    logic             boundary;

    // Channel decode: out-of-range cfg_ch never matches any channel index.
    assign wr_hit   = cfg_wr && (cfg_ch == CH_W'(i));
    assign stall    = (div_q == '0);
    assign run      = en[i] && !stall;
    assign wrap     = run && (cnt_q == div_q - ONE);
    assign cnt_nxt  = wrap ? '0 : cnt_q + ONE;
    // High length rounds up so odd divisors are high one cycle longer.
    assign half     = (div_q >> 1) + {{(DIV_W-1){1'b0}}, div_q[0]};
    assign boundary = wrap || !en[i] || stall;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        cnt_q  <= '0;
        div_q  <= DIV_RST;
        pdiv_q <= DIV_RST;
        pend_q <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        if (pend_q && boundary) begin
          // Apply consumes the previously pending value; a same-edge write re-arms pend.
          div_q  <= pdiv_q;
          cnt_q  <= '0;
          tick_q <= wrap;
          clk_q  <= wrap && (pdiv_q != '0);
          pend_q <= wr_hit;
        end else begin
          if (stall) begin
            cnt_q  <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
          end else if (!en[i]) begin
            tick_q <= 1'b0;
          end else begin
            cnt_q  <= cnt_nxt;
            tick_q <= wrap;
            clk_q  <= (cnt_nxt < half);
          end
          if (wr_hit) pend_q <= 1'b1;
        end
        if (wr_hit) pdiv_q <= cfg_div;
      end
    end

    assign cfg_pend[i] = pend_q;
    assign clk_out[i]  = clk_q;
    assign tick[i]     = tick_q;
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: table-driven run/reconfigure vectors plus
// hand-written sequences for hold, stall, overwrite, out-of-range and reset cases.
module tb_clk_div_prog;
  localparam int unsigned N_CH    = 4;
  localparam int unsigned CH_W    = 3;
  localparam int unsigned DIV_W   = 8;
  localparam int unsigned DEF_DIV = 4;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [N_CH-1:0]   en = '0;
  logic              cfg_wr = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic [N_CH-1:0]   cfg_pend;
  logic [N_CH-1:0]   clk_out;
  logic [N_CH-1:0]   tick;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clk_div_prog #(
    .N_CH(N_CH), .CH_W(CH_W), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV)
  ) dut (
    .clk(clk), .resetn(resetn), .en(en), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_pend(cfg_pend), .clk_out(clk_out), .tick(tick)
  );

  typedef struct {
    logic [3:0] en;
    logic       wr;
    logic [2:0] ch;
    logic [7:0] div;
    logic [3:0] e_clk;
    logic [3:0] e_tick;
    logic [3:0] e_pend;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic step(input logic [3:0] e, input logic w, input logic [2:0] c, input logic [7:0] d);
    en = e; cfg_wr = w; cfg_ch = c; cfg_div = d;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; en = '0; cfg_wr = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    logic [0:9] p_clk10, p_tick10;
    logic [0:5] p_clk6, p_tick6;

    // Run all channels at DEF_DIV=4, then retarget ch0 to D=2 at cnt=1.
    tbl[0]  = '{4'hF, 1'b0, 3'd0, 8'd0, 4'hF, 4'h0, 4'h0};
    tbl[1]  = '{4'hF, 1'b0, 3'd0, 8'd0, 4'h0, 4'h0, 4'h0};
    tbl[2]  = '{4'hF, 1'b0, 3'd0, 8'd0, 4'h0, 4'h0, 4'h0};
    tbl[3]  = '{4'hF, 1'b0, 3'd0, 8'd0, 4'hF, 4'hF, 4'h0};
    tbl[4]  = '{4'hF, 1'b0, 3'd0, 8'd0, 4'hF, 4'h0, 4'h0};
    tbl[5]  = '{4'hF, 1'b0, 3'd0, 8'd0, 4'h0, 4'h0, 4'h0};
    tbl[6]  = '{4'hF, 1'b0, 3'd0, 8'd0, 4'h0, 4'h0, 4'h0};
    tbl[7]  = '{4'hF, 1'b0, 3'd0, 8'd0, 4'hF, 4'hF, 4'h0};
    tbl[8]  = '{4'hF, 1'b0, 3'd0, 8'd0, 4'hF, 4'h0, 4'h0};
    tbl[9]  = '{4'hF, 1'b1, 3'd0, 8'd2, 4'h0, 4'h0, 4'h1};
    tbl[10] = '{4'hF, 1'b0, 3'd0, 8'd0, 4'h0, 4'h0, 4'h1};
    tbl[11] = '{4'hF, 1'b0, 3'd0, 8'd0, 4'hF, 4'hF, 4'h0};
    tbl[12] = '{4'hF, 1'b0, 3'd0, 8'd0, 4'hE, 4'h0, 4'h0};
    tbl[13] = '{4'hF, 1'b0, 3'd0, 8'd0, 4'h1, 4'h1, 4'h0};
    tbl[14] = '{4'hF, 1'b0, 3'd0, 8'd0, 4'h0, 4'h0, 4'h0};
    tbl[15] = '{4'hF, 1'b0, 3'd0, 8'd0, 4'hF, 4'hF, 4'h0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_clk_out", 32'(clk_out), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_pend", 32'(cfg_pend), 32'h0);
    resetn = 1'b1;

    for (int v = 0; v < 16; v++) begin
      step(tbl[v].en, tbl[v].wr, tbl[v].ch, tbl[v].div);
      chk($sformatf("tbl%0d_clk_out", v), 32'(clk_out), 32'(tbl[v].e_clk));
      chk($sformatf("tbl%0d_tick", v), 32'(tick), 32'(tbl[v].e_tick));
      chk($sformatf("tbl%0d_pend", v), 32'(cfg_pend), 32'(tbl[v].e_pend));
    end

    // Async reset mid-period clears outputs and pending state; DEF_DIV restored.
    step(4'hF, 1'b0, 3'd0, 8'd0);
    step(4'hF, 1'b1, 3'd1, 8'd7);
    chk("r6_pend_before", 32'(cfg_pend), 32'h2);
    @(negedge clk);
    resetn = 1'b0; cfg_wr = 1'b0;
    #1;
    chk("r6_clk_out_async", 32'(clk_out), 32'h0);
    chk("r6_tick_async", 32'(tick), 32'h0);
    chk("r6_pend_async", 32'(cfg_pend), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step(4'hF, 1'b0, 3'd0, 8'd0);
      chk($sformatf("r6_tick_e%0d", k), 32'(tick), (k == 4) ? 32'hF : 32'h0);
      chk($sformatf("r6_clk_e%0d", k), 32'(clk_out), (k == 1 || k == 4) ? 32'hF : 32'h0);
    end

    // Write while held applies on the next edge; D=5 gives 3 high / 2 low.
    do_reset();
    step(4'h0, 1'b1, 3'd1, 8'd5);
    chk("t2_pend_set", 32'(cfg_pend), 32'h2);
    step(4'h0, 1'b0, 3'd0, 8'd0);
    chk("t2_pend_clr", 32'(cfg_pend), 32'h0);
    chk("t2_clk_held", 32'(clk_out), 32'h0);
    p_clk10  = 10'b1100111001;
    p_tick10 = 10'b0000100001;
    for (int k = 0; k < 10; k++) begin
      step(4'h2, 1'b0, 3'd0, 8'd0);
      chk($sformatf("t2_clk%0d", k), 32'(clk_out), p_clk10[k] ? 32'h2 : 32'h0);
      chk($sformatf("t2_tick%0d", k), 32'(tick), p_tick10[k] ? 32'h2 : 32'h0);
    end

    // D=0 stalls ch2 at its wrap; a later D=3 applies on the next edge.
    do_reset();
    step(4'h4, 1'b1, 3'd2, 8'd0);
    chk("t4_pend0", 32'(cfg_pend), 32'h4);
    step(4'h4, 1'b0, 3'd0, 8'd0);
    step(4'h4, 1'b0, 3'd0, 8'd0);
    step(4'h4, 1'b0, 3'd0, 8'd0);
    chk("t4_wrap_tick", 32'(tick), 32'h4);
    chk("t4_wrap_clk", 32'(clk_out), 32'h0);
    chk("t4_wrap_pend", 32'(cfg_pend), 32'h0);
    for (int k = 0; k < 2; k++) begin
      step(4'h4, 1'b0, 3'd0, 8'd0);
      chk($sformatf("t4_stall_clk%0d", k), 32'(clk_out), 32'h0);
      chk($sformatf("t4_stall_tick%0d", k), 32'(tick), 32'h0);
    end
    step(4'h4, 1'b1, 3'd2, 8'd3);
    chk("t4_pend3", 32'(cfg_pend), 32'h4);
    chk("t4_stall_clk_w", 32'(clk_out), 32'h0);
    step(4'h4, 1'b0, 3'd0, 8'd0);
    chk("t4_apply_pend", 32'(cfg_pend), 32'h0);
    chk("t4_apply_clk", 32'(clk_out), 32'h0);
    chk("t4_apply_tick", 32'(tick), 32'h0);
    p_clk6  = 6'b101101;
    p_tick6 = 6'b001001;
    for (int k = 0; k < 6; k++) begin
      step(4'h4, 1'b0, 3'd0, 8'd0);
      chk($sformatf("t4_clk%0d", k), 32'(clk_out), p_clk6[k] ? 32'h4 : 32'h0);
      chk($sformatf("t4_tick%0d", k), 32'(tick), p_tick6[k] ? 32'h4 : 32'h0);
    end

    // Last write wins on ch3; out-of-range channel write is ignored.
    do_reset();
    step(4'h8, 1'b1, 3'd3, 8'd6);
    step(4'h8, 1'b1, 3'd3, 8'd8);
    step(4'h8, 1'b1, 3'd5, 8'd1);
    chk("t5_pend_only3", 32'(cfg_pend), 32'h8);
    step(4'h8, 1'b0, 3'd0, 8'd0);
    chk("t5_apply_tick", 32'(tick), 32'h8);
    chk("t5_apply_clk", 32'(clk_out), 32'h8);
    chk("t5_apply_pend", 32'(cfg_pend), 32'h0);
    for (int k = 1; k <= 8; k++) begin
      step(4'h8, 1'b0, 3'd0, 8'd0);
      chk($sformatf("t5_tick%0d", k), 32'(tick), (k == 8) ? 32'h8 : 32'h0);
      chk($sformatf("t5_clk%0d", k), 32'(clk_out), (k < 4 || k == 8) ? 32'h8 : 32'h0);
      chk($sformatf("t5_pend%0d", k), 32'(cfg_pend), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
